// File: rtl/fht_butterfly.sv
// Two-stage radix-2 Hartley butterfly: T = (cos*x1 + sin*x2) >> (W_BIT-1) in stage 1,
// then y0/y1 = sat((x0 +/- T) / 2) in stage 2. x0 arrives one cycle after its x1/x2/coefficients.
module fht_butterfly #(
  parameter int D_BIT = 22,
  parameter int W_BIT = 16
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1
);

  localparam int PW = D_BIT + W_BIT;      // full product width
  localparam int SW = PW + 1;             // sum of two products
  localparam int TW = D_BIT + 2;          // normalized T and x0 +/- T

  localparam logic signed [SW-1:0] ROT_RND = SW'(1) <<< (W_BIT - 2);
  localparam logic signed [TW-1:0] Y_MAX   = TW'((2 ** (D_BIT - 1)) - 1);
  localparam logic signed [TW-1:0] Y_MIN   = -TW'(2 ** (D_BIT - 1));

  logic signed [PW-1:0] prod_cos;
  logic signed [PW-1:0] prod_sin;
  logic signed [SW-1:0] rot_sum;
  logic signed [SW-1:0] rot_shift;
  logic signed [TW-1:0] t_d, t_q;

  logic signed [TW-1:0] x0_ext;
  logic signed [TW-1:0] sum_p, sum_m;
  logic signed [TW-1:0] half_p, half_m;
  logic signed [D_BIT-1:0] y0_d, y0_q;
  logic signed [D_BIT-1:0] y1_d, y1_q;

  function automatic logic signed [D_BIT-1:0] saturate(input logic signed [TW-1:0] v);
    logic signed [D_BIT-1:0] r;
    if (v > Y_MAX)      r = Y_MAX[D_BIT-1:0];
    else if (v < Y_MIN) r = Y_MIN[D_BIT-1:0];
    else                r = v[D_BIT-1:0];
    return r;
  endfunction

  // Stage 1: rotation with round-half-up normalization back to data scale.
  // The shifted sum has exactly TW significant bits, so the slice is lossless.
  always_comb begin
    prod_cos  = PW'(iX_1) * PW'(iCOS);
    prod_sin  = PW'(iX_2) * PW'(iSIN);
    rot_sum   = SW'(prod_cos) + SW'(prod_sin);
    rot_shift = (rot_sum + ROT_RND) >>> (W_BIT - 1);
    t_d       = rot_shift[TW-1:0];
  end

  // Stage 2: halve with round-half-up; |x0 +/- T| < 2^(D_BIT+1) so +1 cannot overflow TW.
  always_comb begin
    x0_ext = TW'(iX_0);
    sum_p  = x0_ext + t_q;
    sum_m  = x0_ext - t_q;
    half_p = (sum_p + TW'(1)) >>> 1;
    half_m = (sum_m + TW'(1)) >>> 1;
    y0_d   = saturate(half_p);
    y1_d   = saturate(half_m);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      t_q  <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      t_q  <= t_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign oY_0 = y0_q;
  assign oY_1 = y1_q;

endmodule

// File: tb/tb_fht_butterfly.sv
// Randomized scoreboard bench for fht_butterfly; expected values come from real-valued
// butterfly math with clamping, checked within 2 LSB.
module tb_fht_butterfly;

  localparam int D_BIT = 22;
  localparam int W_BIT = 16;
  localparam int DMAX  = (1 << (D_BIT - 1)) - 1;
  localparam int DMIN  = -(1 << (D_BIT - 1));

  logic                    iCLK;
  logic                    iRESET;
  logic signed [D_BIT-1:0] iX_0, iX_1, iX_2;
  logic signed [W_BIT-1:0] iSIN, iCOS;
  logic signed [D_BIT-1:0] oY_0, oY_1;

  fht_butterfly #(.D_BIT(D_BIT), .W_BIT(W_BIT)) dut (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .iX_0  (iX_0),
    .iX_1  (iX_1),
    .iX_2  (iX_2),
    .iSIN  (iSIN),
    .iCOS  (iCOS),
    .oY_0  (oY_0),
    .oY_1  (oY_1)
  );

  typedef struct {
    int    due;
    real   y0;
    real   y1;
    real   tol;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // Operand set whose x0 is still outstanding.
  int    p_x1, p_x2, p_c, p_s;
  string p_tag;

  initial begin
    iCLK = 0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic real clampr(input real v);
    if (v > real'(DMAX)) return real'(DMAX);
    if (v < real'(DMIN)) return real'(DMIN);
    return v;
  endfunction

  function automatic int rand_data();
    int r;
    r = int'($urandom);
    return r >>> (32 - D_BIT);
  endfunction

  task automatic check(input string name, input int actual, input real expv, input real tol);
    real d;
    checks++;
    d = real'(actual) - expv;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %f (tol %0.1f) at cycle %0d", name, actual, expv, tol, cyc);
    end
  endtask

  // Monitor: compares every output due this cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge iCLK);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          check({e.tag, "_missed"}, cyc, real'(e.due), 0.0);
        end else begin
          check({e.tag, "_y0"}, int'(oY_0), e.y0, e.tol);
          check({e.tag, "_y1"}, int'(oY_1), e.y1, e.tol);
        end
      end
    end
  end

  task automatic drive(input int x1, input int x2, input int c, input int s, input int x0);
    iX_1 = D_BIT'(x1);
    iX_2 = D_BIT'(x2);
    iCOS = W_BIT'(c);
    iSIN = W_BIT'(s);
    iX_0 = D_BIT'(x0);
  endtask

  // Present a new rotated operand set plus the x0 belonging to the previous one.
  task automatic issue(input int x1, input int x2, input int c, input int s, input int x0,
                       input string tag);
    real  t;
    exp_t e;
    @(posedge iCLK);
    #1;
    iRESET = 0;
    drive(x1, x2, c, s, x0);
    t     = (real'(p_c) * real'(p_x1) + real'(p_s) * real'(p_x2)) / real'(1 << (W_BIT - 1));
    e.due = cyc + 1;
    e.y0  = clampr((real'(x0) + t) / 2.0);
    e.y1  = clampr((real'(x0) - t) / 2.0);
    e.tol = 2.0;
    e.tag = p_tag;
    sb.push_back(e);
    p_x1  = x1;
    p_x2  = x2;
    p_c   = c;
    p_s   = s;
    p_tag = tag;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge iCLK);
      #1;
      iRESET = 1;
      drive(rand_data(), rand_data(), int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, rand_data());
      e.due = cyc + 1;
      e.y0  = 0.0;
      e.y1  = 0.0;
      e.tol = 0.0;
      e.tag = "reset";
      sb.push_back(e);
    end
    // Reset clears T, so the first x0 afterwards pairs with a zero rotation.
    p_x1  = 0;
    p_x2  = 0;
    p_c   = 0;
    p_s   = 0;
    p_tag = "post_reset";
  endtask

  task automatic rand_coef(output int c, output int s);
    real r;
    s = int'($urandom_range(0, 65534)) - 32767;
    r = $sqrt(1073741824.0 - real'(s) * real'(s));
    c = int'(r);
    if (c > 32767) c = 32767;
    if ($urandom_range(0, 1) == 1) c = -c;
  endtask

  int cos45[8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  int sin45[8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

  initial begin
    int c, s;
    int waited;
    iRESET = 1;
    drive(0, 0, 0, 0, 0);

    do_reset(2);

    issue(1000, 0, 32767, 0, rand_data(), "cos_only");
    issue(0, -2000, 0, 32767, 0, "sin_only");
    issue(4096, 4096, 23170, 23170, 400, "rot45");
    issue(DMAX, DMAX, 23170, 23170, 0, "sat_pos");
    issue(DMIN, DMIN, 23170, 23170, DMAX, "sat_neg");
    issue(1234, -5678, 32767, 0, DMIN, "angle");

    for (int k = 0; k < 8; k++) begin
      issue(rand_data() >>> 1, rand_data() >>> 1, cos45[k], sin45[k], rand_data(), "angle");
    end

    for (int i = 0; i < 1000; i++) begin
      rand_coef(c, s);
      issue(rand_data(), rand_data(), c, s, rand_data(), "random");
    end

    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      rand_coef(c, s);
      issue(rand_data(), rand_data(), c, s, rand_data(), "after_reset");
    end
    issue(0, 0, 0, 0, rand_data(), "flush");

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge iCLK);
      waited++;
    end
    @(negedge iCLK);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected results still pending, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
